// File: rtl/xex_sector_controller.sv
// Sequencing controller for an XEX-mode sector engine: encrypts the sector tweak,
// then streams blk_num data blocks through a shared AES core one at a time.
module xex_sector_controller #(
  parameter int unsigned TK_WAIT   = 3,
  parameter int unsigned KEY_WAIT  = 3,
  parameter int unsigned DEC_WAIT  = 14,
  parameter int unsigned BLK_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [1:0]           mode,
  input  logic [BLK_CNT_W-1:0] blk_num,
  input  logic                 aes_rdy,
  input  logic                 aes_bz,
  input  logic                 in_rdy,
  output logic                 d_valid,
  output logic                 d_tk,
  output logic                 tk_ud,
  output logic                 enc_dec,
  output logic                 xex_bz,
  output logic                 out_rdy,
  output logic [BLK_CNT_W-1:0] blk_cnt,
  output logic                 sector_done,
  output logic                 abort
);

  localparam int unsigned WAIT_W = 8;

  typedef enum logic [2:0] {
    IDLE, WAIT_TK, SEND_TK, ENC_TK, WAIT_KEY, WAIT_DEC, DATA, DONE
  } state_t;

  state_t               state, state_d;
  logic [WAIT_W-1:0]    wait_cnt, wait_cnt_d;
  logic [BLK_CNT_W-1:0] blk_cnt_d;
  logic [BLK_CNT_W-1:0] blk_num_q, blk_num_d;
  logic [BLK_CNT_W-1:0] iss_cnt, iss_cnt_d;
  logic [BLK_CNT_W-1:0] blk_last;
  logic                 inflight, inflight_d;
  logic                 last_issued, last_issued_d;
  logic                 enc_dec_d;
  logic                 abort_d;
  logic                 start;
  logic                 aborting;

  // State and datapath registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      blk_cnt     <= '0;
      blk_num_q   <= '0;
      iss_cnt     <= '0;
      inflight    <= 1'b0;
      last_issued <= 1'b0;
      enc_dec     <= 1'b0;
      abort       <= 1'b0;
    end else begin
      state       <= state_d;
      wait_cnt    <= wait_cnt_d;
      blk_cnt     <= blk_cnt_d;
      blk_num_q   <= blk_num_d;
      iss_cnt     <= iss_cnt_d;
      inflight    <= inflight_d;
      last_issued <= last_issued_d;
      enc_dec     <= enc_dec_d;
      abort       <= abort_d;
    end
  end

  // Next-state, datapath updates and strobes
  always_comb begin
    state_d       = state;
    wait_cnt_d    = wait_cnt;
    blk_cnt_d     = blk_cnt;
    blk_num_d     = blk_num_q;
    iss_cnt_d     = iss_cnt;
    inflight_d    = inflight;
    last_issued_d = last_issued;
    enc_dec_d     = enc_dec;
    abort_d       = 1'b0;
    start         = 1'b0;
    d_valid       = 1'b0;
    d_tk          = 1'b1;
    tk_ud         = 1'b0;
    xex_bz        = 1'b1;
    out_rdy       = 1'b0;
    sector_done   = 1'b0;
    blk_last      = blk_num_q - BLK_CNT_W'(1);
    aborting      = ~mode[1] && (state != IDLE) && (state != DONE);

    case (state)
      IDLE: begin
        xex_bz = 1'b0;
        start  = mode[1];
      end
      WAIT_TK: begin
        d_tk = 1'b0;
        if (wait_cnt == WAIT_W'(TK_WAIT - 1)) begin
          state_d    = SEND_TK;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt + WAIT_W'(1);
        end
      end
      SEND_TK: begin
        d_valid = 1'b1;
        d_tk    = 1'b0;
        state_d = ENC_TK;
      end
      ENC_TK: begin
        d_tk  = 1'b0;
        tk_ud = aes_rdy;
        if (aes_rdy) state_d = WAIT_KEY;
      end
      WAIT_KEY: begin
        if (wait_cnt == WAIT_W'(KEY_WAIT - 1)) begin
          state_d    = enc_dec ? WAIT_DEC : DATA;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt + WAIT_W'(1);
        end
      end
      WAIT_DEC: begin
        if (wait_cnt == WAIT_W'(DEC_WAIT - 1)) begin
          state_d    = DATA;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt + WAIT_W'(1);
        end
      end
      DATA: begin
        // One block in flight; a returning result frees the slot in the same cycle
        xex_bz     = aes_bz | inflight;
        d_valid    = in_rdy & (~inflight | aes_rdy) & ~last_issued;
        out_rdy    = aes_rdy;
        tk_ud      = aes_rdy;
        inflight_d = d_valid | (inflight & ~aes_rdy);
        if (d_valid) begin
          iss_cnt_d = iss_cnt + BLK_CNT_W'(1);
          if (iss_cnt == blk_last) last_issued_d = 1'b1;
        end
        if (aes_rdy) begin
          blk_cnt_d = blk_cnt + BLK_CNT_W'(1);
          if (blk_cnt == blk_last) state_d = DONE;
        end
      end
      DONE: begin
        sector_done = 1'b1;
        start       = mode[1];
        if (!mode[1]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d       = WAIT_TK;
      wait_cnt_d    = '0;
      enc_dec_d     = mode[0];
      blk_num_d     = blk_num;
      blk_cnt_d     = '0;
      iss_cnt_d     = '0;
      inflight_d    = 1'b0;
      last_issued_d = 1'b0;
    end

    // Abort wins over any other transition and suppresses this cycle's strobes
    if (aborting) begin
      state_d       = IDLE;
      abort_d       = 1'b1;
      wait_cnt_d    = '0;
      blk_cnt_d     = blk_cnt;
      inflight_d    = 1'b0;
      last_issued_d = 1'b0;
      d_valid       = 1'b0;
      tk_ud         = 1'b0;
      out_rdy       = 1'b0;
    end
  end

endmodule

// File: tb/tb_xex_sector_controller.sv
// Scoreboard bench: stimulus queues expected strobe events with cycle stamps,
// monitors pop and compare whenever a DUT raises any strobe.
module tb_xex_sector_controller;

  typedef struct packed {
    logic        dv;
    logic        dtk;
    logic        tkud;
    logic        ordy;
    logic        sdone;
    logic        abrt;
    logic        enc;
    logic [7:0]  bcnt;
    logic [31:0] cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       n_rst;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  ev_t        q1[$];
  ev_t        q2[$];
  ev_t        got1, exp1, got2, exp2;

  logic [1:0] mode;
  logic [7:0] blk_num;
  logic       aes_rdy, aes_bz, in_rdy;
  logic       d_valid, d_tk, tk_ud, enc_dec, xex_bz, out_rdy, sector_done, abort;
  logic [7:0] blk_cnt;

  logic [1:0] mode2;
  logic [1:0] blk_num2;
  logic       aes_rdy2, aes_bz2, in_rdy2;
  logic       d_valid2, d_tk2, tk_ud2, enc_dec2, xex_bz2, out_rdy2, sector_done2, abort2;
  logic [1:0] blk_cnt2;

  xex_sector_controller u_dut (
    .clk(clk), .n_rst(n_rst), .mode(mode), .blk_num(blk_num),
    .aes_rdy(aes_rdy), .aes_bz(aes_bz), .in_rdy(in_rdy),
    .d_valid(d_valid), .d_tk(d_tk), .tk_ud(tk_ud), .enc_dec(enc_dec),
    .xex_bz(xex_bz), .out_rdy(out_rdy), .blk_cnt(blk_cnt),
    .sector_done(sector_done), .abort(abort)
  );

  xex_sector_controller #(.BLK_CNT_W(2)) u_dut2 (
    .clk(clk), .n_rst(n_rst), .mode(mode2), .blk_num(blk_num2),
    .aes_rdy(aes_rdy2), .aes_bz(aes_bz2), .in_rdy(in_rdy2),
    .d_valid(d_valid2), .d_tk(d_tk2), .tk_ud(tk_ud2), .enc_dec(enc_dec2),
    .xex_bz(xex_bz2), .out_rdy(out_rdy2), .blk_cnt(blk_cnt2),
    .sector_done(sector_done2), .abort(abort2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk(int c, bit dv, bit dtk, bit tkud, bit ordy,
                             bit sdone, bit abrt, bit enc, int b);
    ev_t e;
    e.dv = dv; e.dtk = dtk; e.tkud = tkud; e.ordy = ordy;
    e.sdone = sdone; e.abrt = abrt; e.enc = enc;
    e.bcnt = 8'(b); e.cyc = 32'(c);
    return e;
  endfunction

  function automatic string show(ev_t e);
    return $sformatf("@%0d dv=%b dtk=%b tkud=%b ordy=%b sdone=%b abrt=%b enc=%b bcnt=%0d",
                     e.cyc, e.dv, e.dtk, e.tkud, e.ordy, e.sdone, e.abrt, e.enc, e.bcnt);
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic go(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor for the default-parameter instance
  always @(negedge clk) begin
    if (d_valid | tk_ud | out_rdy | sector_done | abort) begin
      got1.dv = d_valid; got1.dtk = d_tk; got1.tkud = tk_ud; got1.ordy = out_rdy;
      got1.sdone = sector_done; got1.abrt = abort; got1.enc = enc_dec;
      got1.bcnt = blk_cnt; got1.cyc = 32'(cyc);
      checks++;
      if (q1.size() == 0) begin
        failures++;
        $display("FAIL dut1_unexpected_event got %s", show(got1));
      end else begin
        exp1 = q1.pop_front();
        if (got1 !== exp1) begin
          failures++;
          $display("FAIL dut1_event got %s expected %s", show(got1), show(exp1));
        end
      end
    end
  end

  // Monitor for the narrow-counter instance
  always @(negedge clk) begin
    if (d_valid2 | tk_ud2 | out_rdy2 | sector_done2 | abort2) begin
      got2.dv = d_valid2; got2.dtk = d_tk2; got2.tkud = tk_ud2; got2.ordy = out_rdy2;
      got2.sdone = sector_done2; got2.abrt = abort2; got2.enc = enc_dec2;
      got2.bcnt = {6'b0, blk_cnt2}; got2.cyc = 32'(cyc);
      checks++;
      if (q2.size() == 0) begin
        failures++;
        $display("FAIL dut2_unexpected_event got %s", show(got2));
      end else begin
        exp2 = q2.pop_front();
        if (got2 !== exp2) begin
          failures++;
          $display("FAIL dut2_event got %s expected %s", show(got2), show(exp2));
        end
      end
    end
  end

  initial begin
    int t;
    n_rst = 1'b0;
    mode = 2'b00; blk_num = 8'd0; aes_rdy = 1'b0; aes_bz = 1'b0; in_rdy = 1'b0;
    mode2 = 2'b00; blk_num2 = 2'd0; aes_rdy2 = 1'b0; aes_bz2 = 1'b0; in_rdy2 = 1'b0;
    #2;
    chk("rst_d_valid", 32'(d_valid), 0);
    chk("rst_d_tk", 32'(d_tk), 1);
    chk("rst_xex_bz", 32'(xex_bz), 0);
    chk("rst_blk_cnt", 32'(blk_cnt), 0);
    chk("rst_enc_dec", 32'(enc_dec), 0);
    go(3);
    n_rst = 1'b1;

    // Encrypt, 2 blocks, tweak result 4 cycles after SEND_TK
    go(5); t = cyc;
    mode = 2'b10; blk_num = 8'd2;
    q1.push_back(mk(t+4,  1,0,0,0,0,0,0,0));
    q1.push_back(mk(t+8,  0,0,1,0,0,0,0,0));
    q1.push_back(mk(t+12, 1,1,0,0,0,0,0,0));
    q1.push_back(mk(t+14, 1,1,1,1,0,0,0,0));
    q1.push_back(mk(t+16, 0,1,1,1,0,0,0,1));
    q1.push_back(mk(t+17, 0,1,0,0,1,0,0,2));
    go(t+2);  chk("enc_wait_tk_d_tk", 32'(d_tk), 0);
    chk("enc_wait_tk_xex_bz", 32'(xex_bz), 1);
    go(t+8);  aes_rdy = 1'b1;
    go(t+9);  aes_rdy = 1'b0;
    go(t+10); chk("enc_wait_key_d_tk", 32'(d_tk), 1);
    go(t+12); in_rdy = 1'b1;
    go(t+14); aes_rdy = 1'b1;
    go(t+15); aes_rdy = 1'b0;
    go(t+16); aes_rdy = 1'b1;
    go(t+17); aes_rdy = 1'b0; in_rdy = 1'b0; mode = 2'b00;
    go(t+18); chk("enc_idle_xex_bz", 32'(xex_bz), 0);

    // Abort while waiting for the tweak result
    go(t+20); t = cyc;
    mode = 2'b10; blk_num = 8'd2;
    q1.push_back(mk(t+4, 1,0,0,0,0,0,0,0));
    q1.push_back(mk(t+7, 0,1,0,0,0,1,0,0));
    go(t+6); mode = 2'b00;
    go(t+7); chk("abort_enc_xex_bz", 32'(xex_bz), 0);
    go(t+8); chk("abort_enc_pulse_len", 32'(abort), 0);

    // Abort in DATA with a block outstanding; blk_cnt must hold
    go(t+10); t = cyc;
    mode = 2'b10; blk_num = 8'd2;
    q1.push_back(mk(t+4,  1,0,0,0,0,0,0,0));
    q1.push_back(mk(t+5,  0,0,1,0,0,0,0,0));
    q1.push_back(mk(t+9,  1,1,0,0,0,0,0,0));
    q1.push_back(mk(t+11, 1,1,1,1,0,0,0,0));
    q1.push_back(mk(t+14, 0,1,0,0,0,1,0,1));
    go(t+5);  aes_rdy = 1'b1;
    go(t+6);  aes_rdy = 1'b0;
    go(t+9);  in_rdy = 1'b1;
    go(t+11); aes_rdy = 1'b1;
    go(t+12); chk("data_inflight_xex_bz", 32'(xex_bz), 1);
    aes_rdy = 1'b0; in_rdy = 1'b0;
    go(t+13); mode = 2'b00;
    go(t+14); chk("abort_data_blk_cnt", 32'(blk_cnt), 1);
    go(t+15); aes_rdy = 1'b1;
    go(t+16); aes_rdy = 1'b0;

    // Streaming: result every cycle from the second DATA cycle
    go(t+18); t = cyc;
    mode = 2'b10; blk_num = 8'd3;
    q1.push_back(mk(t+4,  1,0,0,0,0,0,0,0));
    q1.push_back(mk(t+5,  0,0,1,0,0,0,0,0));
    q1.push_back(mk(t+9,  1,1,0,0,0,0,0,0));
    q1.push_back(mk(t+10, 1,1,1,1,0,0,0,0));
    q1.push_back(mk(t+11, 1,1,1,1,0,0,0,1));
    q1.push_back(mk(t+12, 0,1,1,1,0,0,0,2));
    q1.push_back(mk(t+13, 0,1,0,0,1,0,0,3));
    go(t+5);  aes_rdy = 1'b1;
    go(t+6);  aes_rdy = 1'b0;
    go(t+9);  in_rdy = 1'b1;
    go(t+10); aes_rdy = 1'b1;
    go(t+13); aes_rdy = 1'b0; in_rdy = 1'b0; mode = 2'b00;

    // Decrypt, 1 block: 14 extra WAIT_DEC cycles, stray aes_rdy ignored
    go(t+16); t = cyc;
    mode = 2'b11; blk_num = 8'd1;
    q1.push_back(mk(t+4,  1,0,0,0,0,0,1,0));
    q1.push_back(mk(t+6,  0,0,1,0,0,0,1,0));
    q1.push_back(mk(t+24, 1,1,0,0,0,0,1,0));
    q1.push_back(mk(t+26, 0,1,1,1,0,0,1,0));
    q1.push_back(mk(t+27, 0,1,0,0,1,0,1,1));
    go(t+6);  aes_rdy = 1'b1;
    go(t+7);  aes_rdy = 1'b0;
    go(t+15); chk("dec_wait_xex_bz", 32'(xex_bz), 1);
    chk("dec_wait_enc_dec", 32'(enc_dec), 1);
    aes_rdy = 1'b1;
    go(t+16); aes_rdy = 1'b0; in_rdy = 1'b1;
    go(t+23); chk("dec_last_wait_d_valid", 32'(d_valid), 0);
    go(t+26); aes_rdy = 1'b1;
    go(t+27); aes_rdy = 1'b0; in_rdy = 1'b0; mode = 2'b00;

    // Reset asserted during WAIT_DEC
    go(t+30); t = cyc;
    mode = 2'b11; blk_num = 8'd1;
    q1.push_back(mk(t+4, 1,0,0,0,0,0,1,0));
    q1.push_back(mk(t+6, 0,0,1,0,0,0,1,0));
    go(t+6);  aes_rdy = 1'b1;
    go(t+7);  aes_rdy = 1'b0;
    go(t+15); chk("pre_rst_enc_dec", 32'(enc_dec), 1);
    n_rst = 1'b0;
    #1;
    chk("mid_rst_d_valid", 32'(d_valid), 0);
    chk("mid_rst_d_tk", 32'(d_tk), 1);
    chk("mid_rst_tk_ud", 32'(tk_ud), 0);
    chk("mid_rst_enc_dec", 32'(enc_dec), 0);
    chk("mid_rst_xex_bz", 32'(xex_bz), 0);
    chk("mid_rst_out_rdy", 32'(out_rdy), 0);
    chk("mid_rst_blk_cnt", 32'(blk_cnt), 0);
    chk("mid_rst_sector_done", 32'(sector_done), 0);
    chk("mid_rst_abort", 32'(abort), 0);
    mode = 2'b00;
    go(t+17); n_rst = 1'b1;
    go(t+19); chk("post_rst_abort", 32'(abort), 0);

    // 2-bit counter, blk_num=0 means 4 blocks, then back-to-back sector
    go(t+21); t = cyc;
    mode2 = 2'b10; blk_num2 = 2'd0;
    q2.push_back(mk(t+4,  1,0,0,0,0,0,0,0));
    q2.push_back(mk(t+5,  0,0,1,0,0,0,0,0));
    q2.push_back(mk(t+9,  1,1,0,0,0,0,0,0));
    q2.push_back(mk(t+10, 1,1,1,1,0,0,0,0));
    q2.push_back(mk(t+11, 1,1,1,1,0,0,0,1));
    q2.push_back(mk(t+12, 1,1,1,1,0,0,0,2));
    q2.push_back(mk(t+13, 0,1,1,1,0,0,0,3));
    q2.push_back(mk(t+14, 0,1,0,0,1,0,0,0));
    q2.push_back(mk(t+18, 1,0,0,0,0,0,0,0));
    q2.push_back(mk(t+20, 0,1,0,0,0,1,0,0));
    go(t+5);  aes_rdy2 = 1'b1;
    go(t+6);  aes_rdy2 = 1'b0;
    go(t+9);  in_rdy2 = 1'b1;
    go(t+10); aes_rdy2 = 1'b1;
    go(t+14); aes_rdy2 = 1'b0; in_rdy2 = 1'b0;
    go(t+16); chk("w2_b2b_xex_bz", 32'(xex_bz2), 1);
    chk("w2_b2b_d_tk", 32'(d_tk2), 0);
    go(t+19); mode2 = 2'b00;
    go(t+23);

    chk("dut1_queue_drained", 32'(q1.size()), 0);
    chk("dut2_queue_drained", 32'(q2.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
